// File: rtl/fall_scheduler_pkg.sv
// fall_scheduler_pkg: shared game geometry, coordinate width and scheduler state encoding
package fall_scheduler_pkg;
  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
  localparam int FLOOR_Y = 600;
  localparam int COORD_W = 12;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;
  localparam logic [1:0] ST_FROZEN = 2'd3;
endpackage

// File: rtl/fall_scheduler_step.sv
// fall_step: one slot's per-frame gravity move, floor clamp and velocity saturation
module fall_step
  import fall_scheduler_pkg::*;
#(
  parameter int FLOOR_Y = 600,
  parameter int GRAVITY = 1,
  parameter int VMAX = 16
) (
  input  logic [COORD_W-1:0] y,
  input  logic [7:0]         vel,
  input  logic               hit,
  output logic [COORD_W-1:0] y_next,
  output logic [7:0]         vel_next,
  output logic               landed
);
  logic [COORD_W:0] y_sum;
  logic [8:0] v_sum;
  logic floor_reach;
  always_comb begin
    y_sum = {1'b0, y} + (COORD_W+1)'(vel);
    floor_reach = y_sum >= (COORD_W+1)'(FLOOR_Y);
    v_sum = 9'(vel) + 9'(GRAVITY);
    landed = hit | floor_reach;
    y_next = hit ? y : floor_reach ? COORD_W'(FLOOR_Y) : y_sum[COORD_W-1:0];
    vel_next = v_sum > 9'(VMAX) ? 8'(VMAX) : v_sum[7:0];
  end
endmodule

// File: rtl/fall_scheduler.sv
// fall_scheduler: allocates falling-object slots and sweeps them once per frame
// through a single shared fall_step datapath.
module fall_scheduler #(
  parameter int SLOTS = 4,
  parameter int FLOOR_Y = fall_scheduler_pkg::FLOOR_Y,
  parameter int SPAWN_Y = 0,
  parameter int GRAVITY = 1,
  parameter int VMAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ending,
  input  logic               frame_tick,
  input  logic               spawn_req,
  input  logic [11:0]        spawn_x,
  output logic               spawn_ack,
  input  logic [SLOTS-1:0]   floor_hit,
  output logic [12*SLOTS-1:0] obj_x,
  output logic [12*SLOTS-1:0] obj_y,
  output logic [SLOTS-1:0]   obj_active,
  output logic               land_valid,
  output logic [2:0]         land_slot,
  output logic               busy,
  output logic               overrun
);
  import fall_scheduler_pkg::*;
  localparam int IW = $clog2(SLOTS);
  logic [1:0] state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, free_idx;
  logic [11:0] x_q [SLOTS], x_d [SLOTS], y_q [SLOTS], y_d [SLOTS];
  logic [7:0] vel_q [SLOTS], vel_d [SLOTS];
  logic [SLOTS-1:0] act_q, act_d;
  logic ack_q, ack_d, land_q, land_d, overrun_q, overrun_d, free_ok, clear;
  logic [2:0] land_slot_q, land_slot_d;
  logic [11:0] y_nx;
  logic [7:0] vel_nx;
  logic landed;

  fall_step #(.FLOOR_Y(FLOOR_Y), .GRAVITY(GRAVITY), .VMAX(VMAX)) u_step (
    .y(y_q[idx_q]), .vel(vel_q[idx_q]), .hit(floor_hit[idx_q]),
    .y_next(y_nx), .vel_next(vel_nx), .landed(landed)
  );

  always_comb begin
    free_ok = 1'b0;
    free_idx = '0;
    for (int i = SLOTS-1; i >= 0; i--)
      if (!act_q[i]) begin
        free_ok = 1'b1;
        free_idx = IW'(i);
      end
  end

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    x_d = x_q;
    y_d = y_q;
    vel_d = vel_q;
    act_d = act_q;
    ack_d = 1'b0;
    land_d = 1'b0;
    land_slot_d = land_slot_q;
    overrun_d = overrun_q | (state_q == ST_SWEEP & frame_tick);
    clear = 1'b0;
    // ending preempts every non-idle state, even mid-sweep
    if (ending && state_q != ST_IDLE) state_d = ST_FROZEN;
    else if (state_q == ST_IDLE) begin
      clear = 1'b1;
      if (start) state_d = ST_RUN;
    end else if (state_q == ST_FROZEN) begin
      if (!start) begin
        state_d = ST_IDLE;
        clear = 1'b1;
      end
    end else if (state_q == ST_RUN) begin
      if (frame_tick) begin
        state_d = ST_SWEEP;
        idx_d = '0;
      end else if (spawn_req && free_ok && !ack_q) begin
        x_d[free_idx] = spawn_x;
        y_d[free_idx] = 12'(SPAWN_Y);
        vel_d[free_idx] = '0;
        act_d[free_idx] = 1'b1;
        ack_d = 1'b1;
      end
    end else begin
      if (act_q[idx_q]) begin
        y_d[idx_q] = y_nx;
        vel_d[idx_q] = vel_nx;
        if (landed) begin
          act_d[idx_q] = 1'b0;
          land_d = 1'b1;
          land_slot_d = 3'(idx_q);
        end
      end
      idx_d = idx_q + 1'b1;
      if (idx_q == IW'(SLOTS-1)) begin
        state_d = ST_RUN;
        idx_d = '0;
      end
    end
    if (clear) begin
      act_d = '0;
      overrun_d = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        x_d[i] = '0;
        y_d[i] = '0;
        vel_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      x_q <= '{default: '0};
      y_q <= '{default: '0};
      vel_q <= '{default: '0};
      act_q <= '0;
      ack_q <= 1'b0;
      land_q <= 1'b0;
      land_slot_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      x_q <= x_d;
      y_q <= y_d;
      vel_q <= vel_d;
      act_q <= act_d;
      ack_q <= ack_d;
      land_q <= land_d;
      land_slot_q <= land_slot_d;
      overrun_q <= overrun_d;
    end

  always_comb begin
    obj_x = '0;
    obj_y = '0;
    for (int i = 0; i < SLOTS; i++) begin
      obj_x[12*i +: 12] = x_q[i];
      obj_y[12*i +: 12] = y_q[i];
    end
  end

  assign obj_active = act_q;
  assign spawn_ack = ack_q;
  assign land_valid = land_q;
  assign land_slot = land_slot_q;
  assign busy = state_q == ST_SWEEP;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_fall_scheduler.sv
// tb_fall_scheduler: directed scenarios against a small slot model with spawn/land scoreboards
module tb_fall_scheduler;
  logic clk = 0, rst = 0, start = 0, ending = 0, frame_tick = 0, spawn_req = 0;
  logic [11:0] spawn_x = 0;
  logic [3:0] floor_hit = 0;
  logic spawn_ack, land_valid, busy, overrun;
  logic [47:0] obj_x, obj_y;
  logic [3:0] obj_active, prev_act = 0;
  logic [2:0] land_slot;
  int checks = 0, failures = 0;
  int land_q[$], slot_q[$], ytab_q[$];
  int m_y[4], m_v[4], m_x[4];
  bit m_a[4];

  fall_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .ending(ending), .frame_tick(frame_tick),
    .spawn_req(spawn_req), .spawn_x(spawn_x), .spawn_ack(spawn_ack), .floor_hit(floor_hit),
    .obj_x(obj_x), .obj_y(obj_y), .obj_active(obj_active), .land_valid(land_valid),
    .land_slot(land_slot), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (land_valid) begin
      if (land_q.size() == 0) chk("land_unexpected", 32'(land_slot), 99);
      else chk("land_slot", 32'(land_slot), land_q.pop_front());
      chk("land_act_fall", {prev_act[land_slot], obj_active[land_slot]}, 2);
    end
    prev_act = obj_active;
  end

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_y[i] = 0; m_v[i] = 0; m_x[i] = 0; m_a[i] = 0;
    end
  endfunction

  function automatic void upd(input int i, input logic [3:0] hit);
    if (!m_a[i]) return;
    if (hit[i]) m_a[i] = 0;
    else if (m_y[i] + m_v[i] >= 600) begin m_y[i] = 600; m_a[i] = 0; end
    else m_y[i] += m_v[i];
    if (!m_a[i]) land_q.push_back(i);
    m_v[i] = m_v[i] >= 15 ? 16 : m_v[i] + 1;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) if (!m_a[i]) return i;
    return -1;
  endfunction

  task automatic cmp_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_y%0d", tag, i), 32'(obj_y[12*i +: 12]), m_y[i]);
      chk($sformatf("%s_x%0d", tag, i), 32'(obj_x[12*i +: 12]), m_x[i]);
      chk($sformatf("%s_act%0d", tag, i), 32'(obj_active[i]), 32'(m_a[i]));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_act"}, 32'(obj_active), 0);
    chk({tag, "_ack"}, 32'(spawn_ack), 0);
    chk({tag, "_land"}, 32'(land_valid), 0);
    chk({tag, "_lslot"}, 32'(land_slot), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ovr"}, 32'(overrun), 0);
    chk({tag, "_xy0"}, 32'(obj_x === 48'd0 && obj_y === 48'd0), 1);
  endtask

  task automatic frame(input logic [3:0] hit, input bit extra);
    int nb;
    for (int i = 0; i < 4; i++) upd(i, hit);
    @(posedge clk); #1 frame_tick = 1; floor_hit = hit;
    @(posedge clk); #1 frame_tick = 0;
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      frame_tick = extra && nb == 1;
    end
    frame_tick = 0;
    floor_hit = 0;
    chk("busy_len", nb, 4);
    cmp_all("frame");
  endtask

  task automatic spawn_begin(input int x, input int exp);
    slot_q.push_back(exp);
    @(posedge clk); #1 spawn_req = 1; spawn_x = 12'(x);
  endtask

  task automatic spawn_wait(output int lat);
    int s, l;
    for (l = 0; l < 40; l++) begin
      @(negedge clk);
      if (spawn_ack) break;
    end
    lat = l;
    chk("ack_timeout", 32'(l < 40), 1);
    spawn_req = 0;
    s = slot_q.pop_front();
    chk("spawn_x", 32'(obj_x[12*s +: 12]), 32'(spawn_x));
    chk("spawn_y", 32'(obj_y[12*s +: 12]), 0);
    chk("spawn_act", 32'(obj_active[s]), 1);
    m_a[s] = 1; m_y[s] = 0; m_v[s] = 0; m_x[s] = int'(spawn_x);
    @(negedge clk);
    chk("ack_pulse", 32'(spawn_ack), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s, yprev, ysave;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk); #1 rst = 1; start = 1;
    @(posedge clk); #1;
    spawn_begin(100, 0);
    spawn_wait(lat);
    chk("ack_lat", lat, 1);
    cmp_all("spawn1");
    ytab_q = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 45};
    for (int f = 0; f < 10; f++) begin
      frame(4'b0000, 0);
      chk($sformatf("ytab%0d", f), 32'(obj_y[11:0]), ytab_q.pop_front());
    end
    yprev = 45;
    for (int f = 10; f < 60 && m_a[0]; f++) begin
      frame(4'b0000, 0);
      if (f == 25) chk("vmax_step", 32'(int'(obj_y[11:0]) - yprev), 16);
      yprev = int'(obj_y[11:0]);
    end
    chk("floor_y", 32'(obj_y[11:0]), 600);
    chk("landed_off", 32'(obj_active[0]), 0);
    chk("land_drained", land_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      spawn_begin(10 + 10 * i, lowest_free());
      spawn_wait(lat);
    end
    cmp_all("fill");
    slot_q.push_back(1);
    @(posedge clk); #1 spawn_req = 1; spawn_x = 12'd50;
    s = 0;
    repeat (6) begin @(negedge clk); s += int'(spawn_ack); end
    chk("full_noack", s, 0);
    frame(4'b0010, 0);
    spawn_wait(lat);
    chk("refill_all", 32'(obj_active), 4'hF);
    frame(4'b0000, 0);
    ysave = int'(obj_y[35:24]);
    frame(4'b0100, 0);
    chk("hit_hold", 32'(obj_y[35:24]), ysave);
    chk("hit_retire", 32'(obj_active), 4'b1011);
    frame(4'b0000, 1);
    chk("overrun", 32'(overrun), 1);
    s = 0;
    repeat (3) begin @(negedge clk); s += int'(busy); end
    chk("no_resweep", s, 0);
    upd(0, 4'b0000);
    @(posedge clk); #1 frame_tick = 1;
    @(posedge clk); #1 frame_tick = 0;
    @(posedge clk); #1 ending = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("frozen_busy", 32'(busy), 0);
    cmp_all("frozen");
    frame_tick = 1; spawn_req = 1; spawn_x = 12'd7;
    s = 0;
    repeat (4) begin @(negedge clk); s += int'(spawn_ack) + int'(busy); end
    frame_tick = 0; spawn_req = 0;
    chk("frozen_quiet", s, 0);
    cmp_all("frozen_hold");
    chk("frozen_ovr", 32'(overrun), 1);
    ending = 0; start = 0;
    @(negedge clk);
    model_clear();
    cmp_all("idle");
    chk("idle_ovr", 32'(overrun), 0);
    @(posedge clk); #1 start = 1;
    spawn_begin(300, 0);
    spawn_wait(lat);
    @(posedge clk); #1 frame_tick = 1;
    @(posedge clk); #1 frame_tick = 0;
    @(negedge clk);
    chk("busy_pre_rst", 32'(busy), 1);
    rst = 0;
    #1 chk_reset("midrst");
    @(negedge clk);
    chk("midrst_noland", 32'(land_valid), 0);
    chk("land_q_empty", land_q.size(), 0);
    chk("slot_q_empty", slot_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
